// File: rtl/mopshub_adc_poll_scheduler.sv
// ADC readout poll scheduler: walks active buses and channels, one request in flight at a time.
// Optional build macro POLL_RETRY_EN: reissue a timed-out request once before declaring it lost.
module mopshub_adc_poll_scheduler #(
    parameter int N_BUS_MAX   = 16,
    parameter int N_CH        = 32,
    parameter int TIMEOUT_CYC = 4000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [4:0]           n_buses,
    input  logic [N_BUS_MAX-1:0] bus_mask,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [4:0]           req_bus,
    output logic [5:0]           req_ch,
    input  logic                 rsp_valid,
    input  logic [4:0]           rsp_bus,
    output logic                 busy,
    output logic                 sweep_done,
    output logic [7:0]           timeout_cnt,
    output logic [4:0]           err_bus
);

    localparam int              TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [5:0]      CH_LAST  = 6'(N_CH - 1);
    localparam logic [5:0]      BUS_MAX  = 6'(N_BUS_MAX);

    typedef enum logic [2:0] {IDLE, SELECT, REQ, WAIT, NEXT, DONE} state_t;

    state_t             state, state_nxt;
    logic [5:0]         bus, bus_nxt;
    logic [5:0]         ch, ch_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [7:0]         tcnt_nxt;
    logic [4:0]         err_nxt;
    logic [5:0]         n_clamped;
    logic [N_BUS_MAX-1:0] mask_sh;
    logic               mask_bit;
    logic               rsp_match;
    logic               retry_avail;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign n_clamped = ({1'b0, n_buses} > BUS_MAX) ? BUS_MAX : {1'b0, n_buses};
    assign mask_sh   = bus_mask >> bus;
    assign mask_bit  = mask_sh[0];
    assign rsp_match = rsp_valid && (rsp_bus == bus[4:0]);
    assign req_bus   = bus[4:0];
    assign req_ch    = ch;

`ifdef POLL_RETRY_EN
    // Set once the current transaction has used its single retry; cleared per new request.
    logic retry_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retry_q <= 1'b0;
        end else if (state == SELECT) begin
            retry_q <= 1'b0;
        end else if (state == WAIT && state_nxt == REQ) begin
            retry_q <= 1'b1;
        end
    end
    assign retry_avail = !retry_q;
`else
    assign retry_avail = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        bus_nxt   = bus;
        ch_nxt    = ch;
        timer_nxt = timer;
        tcnt_nxt  = timeout_cnt;
        err_nxt   = err_bus;
        case (state)
            IDLE: begin
                if (enable && n_clamped != 6'd0) begin
                    state_nxt = SELECT;
                    bus_nxt   = 6'd0;
                    ch_nxt    = 6'd0;
                end
            end
            SELECT: begin
                if (bus >= n_clamped) begin
                    state_nxt = DONE;
                end else if (!mask_bit) begin
                    bus_nxt = bus + 6'd1;
                    ch_nxt  = 6'd0;
                end else begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // An accepted handshake wins over a simultaneous enable drop.
                if (req_valid && req_ready) begin
                    state_nxt = WAIT;
                    timer_nxt = '0;
                end else if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (rsp_match) begin
                    state_nxt = NEXT;
                end else if (timer == TMR_LAST) begin
                    if (retry_avail) begin
                        state_nxt = REQ;
                        timer_nxt = '0;
                    end else begin
                        tcnt_nxt  = sat_inc8(timeout_cnt);
                        err_nxt   = bus[4:0];
                        ch_nxt    = CH_LAST;
                        state_nxt = NEXT;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            NEXT: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SELECT;
                    if (ch == CH_LAST) begin
                        ch_nxt  = 6'd0;
                        bus_nxt = bus + 6'd1;
                    end else begin
                        ch_nxt = ch + 6'd1;
                    end
                end
            end
            DONE: begin
                if (enable) begin
                    state_nxt = SELECT;
                    bus_nxt   = 6'd0;
                    ch_nxt    = 6'd0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they align with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bus         <= 6'd0;
            ch          <= 6'd0;
            timer       <= '0;
            timeout_cnt <= 8'd0;
            err_bus     <= 5'd0;
            req_valid   <= 1'b0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            bus         <= bus_nxt;
            ch          <= ch_nxt;
            timer       <= timer_nxt;
            timeout_cnt <= tcnt_nxt;
            err_bus     <= err_nxt;
            req_valid   <= (state_nxt == REQ);
            busy        <= (state_nxt != IDLE);
            sweep_done  <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_mopshub_adc_poll_scheduler.sv
// Bench for mopshub_adc_poll_scheduler: responder environment plus a sweep-level reference model.
module tb_mopshub_adc_poll_scheduler;

    localparam int N_BUS_MAX   = 16;
    localparam int N_CH        = 4;
    localparam int TIMEOUT_CYC = 16;
`ifdef POLL_RETRY_EN
    localparam int ATTEMPTS = 2;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [4:0]  n_buses = 5'd0;
    logic [15:0] bus_mask = 16'd0;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [4:0]  rsp_bus = 5'd0;
    logic        req_valid;
    logic [4:0]  req_bus;
    logic [5:0]  req_ch;
    logic        busy;
    logic        sweep_done;
    logic [7:0]  timeout_cnt;
    logic [4:0]  err_bus;

    mopshub_adc_poll_scheduler #(
        .N_BUS_MAX(N_BUS_MAX), .N_CH(N_CH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .n_buses(n_buses), .bus_mask(bus_mask),
        .req_valid(req_valid), .req_ready(req_ready), .req_bus(req_bus), .req_ch(req_ch),
        .rsp_valid(rsp_valid), .rsp_bus(rsp_bus), .busy(busy), .sweep_done(sweep_done),
        .timeout_cnt(timeout_cnt), .err_bus(err_bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          obs_q[$];
    int          exp_q[$];
    logic [31:0] dead_mask = 32'd0;
    int          rsp_delay = 5;
    int          rsp_cd = 0;
    logic [4:0]  rsp_tgt = 5'd0;
    logic        noise_en = 1'b0;
    logic [4:0]  noise_bus = 5'd3;
    int          exp_tcnt = 0;
    int          exp_err = 0;
    int          cyc = 0;
    int          rsp_cyc = 0;

    // Receive-path responder and request monitor, evaluated away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        rsp_valid = 1'b0;
        if (noise_en) begin
            rsp_valid = 1'b1;
            rsp_bus = noise_bus;
        end
        if (rsp_cd > 0) begin
            rsp_cd = rsp_cd - 1;
            if (rsp_cd == 0) begin
                rsp_valid = 1'b1;
                rsp_bus = rsp_tgt;
                rsp_cyc = cyc;
            end
        end
        if (rst && req_valid && req_ready) begin
            obs_q.push_back(int'(req_bus) * 64 + int'(req_ch));
            if (!dead_mask[req_bus]) begin
                rsp_cd = rsp_delay;
                rsp_tgt = req_bus;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Expected request list of one sweep, straight from the polling rules.
    task automatic model_sweep(input int n, input logic [31:0] mask, input logic [31:0] dead,
                               input int delay);
        int nc;
        nc = (n > N_BUS_MAX) ? N_BUS_MAX : n;
        exp_q.delete();
        for (int b = 0; b < nc; b++) begin
            if (mask[b]) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (dead[b] || delay > TIMEOUT_CYC) begin
                        for (int a = 0; a < ATTEMPTS; a++) exp_q.push_back(b * 64 + c);
                        exp_tcnt = (exp_tcnt >= 255) ? 255 : exp_tcnt + 1;
                        exp_err = b;
                        break;
                    end
                    exp_q.push_back(b * 64 + c);
                end
            end
        end
    endtask

    task automatic run_sweep(input string name, input int n, input logic [31:0] mask,
                             input logic [31:0] dead, input int delay);
        int guard;
        bit seen;
        obs_q.delete();
        model_sweep(n, mask, dead, delay);
        n_buses = n[4:0];
        bus_mask = mask[15:0];
        dead_mask = dead;
        rsp_delay = delay;
        req_ready = 1'b1;
        enable = 1'b1;
        guard = 0;
        seen = 1'b0;
        while (!seen && guard < 20000) begin
            tick();
            guard++;
            if (sweep_done) begin
                seen = 1'b1;
                enable = 1'b0;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s sweep_done: got none within %0d cycles, required one pulse", name, guard);
        end
        tick();
        n_cmp++;
        if (sweep_done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_done: sweep_done=%0b busy=%0b, required 0/0", name, sweep_done, busy);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s req_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] != exp_q[i]) begin
                n_err++;
                $display("FAIL %s req[%0d]: got bus %0d ch %0d required bus %0d ch %0d", name, i,
                         obs_q[i] / 64, obs_q[i] % 64, exp_q[i] / 64, exp_q[i] % 64);
            end
        end
        n_cmp++;
        if (timeout_cnt !== 8'(exp_tcnt) || err_bus !== 5'(exp_err)) begin
            n_err++;
            $display("FAIL %s errors: timeout_cnt=%0d err_bus=%0d required %0d/%0d", name,
                     timeout_cnt, err_bus, exp_tcnt, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (req_valid !== 1'b0 || req_bus !== 5'd0 || req_ch !== 6'd0 || busy !== 1'b0 ||
            sweep_done !== 1'b0 || timeout_cnt !== 8'd0 || err_bus !== 5'd0) begin
            n_err++;
            $display("FAIL reset_state: vld=%0b bus=%0d ch=%0d busy=%0b done=%0b tcnt=%0d err=%0d required all 0",
                     req_valid, req_bus, req_ch, busy, sweep_done, timeout_cnt, err_bus);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_sweeps();
        run_sweep("two_bus", 2, 32'hFFFF, 32'd0, 5);
        run_sweep("masked", 3, 32'h0005, 32'd0, 3);
        run_sweep("clamp", 20, 32'hFFFF, 32'd0, 1);
    endtask

    task automatic test_timeouts();
        run_sweep("dead_bus1", 3, 32'hFFFF, 32'h0002, 4);
        noise_en = 1'b1;
        run_sweep("noise_bus3", 1, 32'h0001, 32'h0001, 2);
        noise_en = 1'b0;
        run_sweep("rsp_on_expiry", 1, 32'h0001, 32'd0, TIMEOUT_CYC);
        run_sweep("rsp_after_expiry", 1, 32'h0001, 32'd0, TIMEOUT_CYC + 1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int          n;
            int          d;
            logic [31:0] m;
            logic [31:0] dd;
            n = int'($urandom_range(1, 6));
            d = int'($urandom_range(1, 20));
            m = {16'd0, 16'($urandom)};
            dd = 32'd0;
            for (int b = 0; b < 16; b++) dd[b] = ($urandom_range(0, 5) == 0);
            run_sweep("random", n, m, dd, d);
        end
    endtask

    task automatic test_zero_buses();
        obs_q.delete();
        n_buses = 5'd0;
        bus_mask = 16'hFFFF;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (busy !== 1'b0 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL zero_buses: busy=%0b requests=%0d required 0/0", busy, obs_q.size());
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_enable_drop_wait();
        int guard;
        obs_q.delete();
        n_buses = 5'd1;
        bus_mask = 16'h0001;
        dead_mask = 32'd0;
        rsp_delay = 8;
        req_ready = 1'b1;
        enable = 1'b1;
        guard = 0;
        while (obs_q.size() == 0 && guard < 100) begin tick(); guard++; end
        tick();
        enable = 1'b0;
        guard = 0;
        while (busy && guard < 100) begin tick(); guard++; end
        n_cmp++;
        if (busy !== 1'b0 || cyc - rsp_cyc != 2) begin
            n_err++;
            $display("FAIL drop_in_wait: busy=%0b idle %0d cycles after response, required 0 after 2",
                     busy, cyc - rsp_cyc);
        end
        n_cmp++;
        if (obs_q.size() != 1 || timeout_cnt !== 8'(exp_tcnt)) begin
            n_err++;
            $display("FAIL drop_in_wait_result: requests=%0d tcnt=%0d required 1/%0d",
                     obs_q.size(), timeout_cnt, exp_tcnt);
        end
    endtask

    task automatic test_withdraw_and_reset();
        int guard;
        obs_q.delete();
        n_buses = 5'd1;
        bus_mask = 16'h0001;
        req_ready = 1'b0;
        enable = 1'b1;
        guard = 0;
        while (!req_valid && guard < 50) begin tick(); guard++; end
        enable = 1'b0;
        tick();
        n_cmp++;
        if (req_valid !== 1'b0 || busy !== 1'b0 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL withdraw: req_valid=%0b busy=%0b requests=%0d required 0/0/0",
                     req_valid, busy, obs_q.size());
        end
        enable = 1'b1;
        guard = 0;
        while (!req_valid && guard < 50) begin tick(); guard++; end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req_valid !== 1'b0 || busy !== 1'b0 || timeout_cnt !== 8'd0 || err_bus !== 5'd0) begin
            n_err++;
            $display("FAIL reset_mid_req: req_valid=%0b busy=%0b tcnt=%0d err=%0d required all 0",
                     req_valid, busy, timeout_cnt, err_bus);
        end
        exp_tcnt = 0;
        exp_err = 0;
        enable = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        int guard;
        int pulses;
        int bad;
        obs_q.delete();
        n_buses = 5'd1;
        bus_mask = 16'h0001;
        dead_mask = 32'h0001;
        req_ready = 1'b1;
        enable = 1'b1;
        guard = 0;
        pulses = 0;
        while (pulses < 300 && guard < 30000) begin
            tick();
            guard++;
            if (sweep_done) begin
                pulses++;
                if (pulses == 300) enable = 1'b0;
            end
        end
        enable = 1'b0;
        exp_tcnt = (exp_tcnt + 300 > 255) ? 255 : exp_tcnt + 300;
        exp_err = 0;
        tick();
        n_cmp++;
        if (pulses != 300 || timeout_cnt !== 8'(exp_tcnt) || err_bus !== 5'(exp_err)) begin
            n_err++;
            $display("FAIL saturation: sweeps=%0d tcnt=%0d err=%0d required 300/%0d/%0d",
                     pulses, timeout_cnt, err_bus, exp_tcnt, exp_err);
        end
        bad = 0;
        foreach (obs_q[i]) if (obs_q[i] != 0) bad++;
        n_cmp++;
        if (obs_q.size() != 300 * ATTEMPTS || bad != 0) begin
            n_err++;
            $display("FAIL saturation_reqs: requests=%0d non_bus0ch0=%0d required %0d/0",
                     obs_q.size(), bad, 300 * ATTEMPTS);
        end
        dead_mask = 32'd0;
    endtask

    initial begin
        test_reset();
        test_basic_sweeps();
        test_timeouts();
        test_zero_buses();
        test_enable_drop_wait();
        test_random();
        test_withdraw_and_reset();
        test_saturation();
        run_sweep("post_saturation", 2, 32'h0003, 32'h0002, 6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
